// File: rtl/instr_cache_repl_ctlr.sv
// Instruction-cache refill controller: on a fetch miss it requests the
// aligned block from memory, forwards each returned 64-bit beat to the
// cache set as a replacement word, and pulses refill_done_o at the end.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no refill outstanding, waiting for a fetch miss
// REQ   | refill request presented to memory, waiting for ack
// FILL  | collecting return beats and writing them into the set
// DONE  | final beat on the grant port, one-cycle completion pulse
module instr_cache_repl_ctlr #(
    parameter int B     = 64,
    parameter int BEATS = B / 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ic_miss_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    output logic        ic_repl_grant_o,
    output logic [63:0] rep_word_o,
    output logic        stall_o,
    output logic        refill_done_o
);

    localparam int          CNT_W     = $clog2(BEATS) + 1;
    localparam logic [31:0] ADDR_MASK = ~(32'(B) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic               flush_pend;
    logic               beat_take;
    logic               last_beat;

    // flush_pend is bookkeeping only: a flush during the refill never aborts
    // it, so nothing downstream consumes the flag yet.
    logic unused_flush_pend;
    assign unused_flush_pend = flush_pend;

    assign beat_take = (state == FILL) && mem_rvalid_i;
    assign last_beat = beat_take && (beat_cnt == CNT_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack beats a same-cycle flush in REQ
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ic_miss_i && !flush_i) state_nxt = REQ;
            REQ: begin
                if (mem_ack_i)    state_nxt = FILL;
                else if (flush_i) state_nxt = IDLE;
            end
            FILL: if (last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded straight from state
    always_comb begin
        mem_req_o     = (state == REQ);
        refill_done_o = (state == DONE);
        stall_o       = (state != IDLE);
    end

    // Refill address capture, block-aligned, held until the next miss
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_addr_o <= '0;
        end else if (state == IDLE && ic_miss_i && !flush_i) begin
            mem_addr_o <= pc_i & ADDR_MASK;
        end
    end

    // Beat forwarding: one grant per accepted beat, word held across gaps
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ic_repl_grant_o <= 1'b0;
            rep_word_o      <= '0;
            beat_cnt        <= '0;
        end else begin
            ic_repl_grant_o <= beat_take;
            if (beat_take) begin
                rep_word_o <= mem_rdata_i;
                beat_cnt   <= beat_cnt + CNT_W'(1);
            end else if (state == REQ && mem_ack_i) begin
                beat_cnt <= '0;
            end
        end
    end

    // Remember a flush that arrived once the refill was committed
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            flush_pend <= 1'b0;
        end else if (state == DONE) begin
            flush_pend <= 1'b0;
        end else if (flush_i && ((state == REQ && mem_ack_i) || state == FILL)) begin
            flush_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_cache_repl_ctlr.sv
// Directed bench for the instruction-cache refill controller.
module tb_instr_cache_repl_ctlr;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        ic_miss_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        ic_repl_grant_o;
    logic [63:0] rep_word_o;
    logic        stall_o;
    logic        refill_done_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    logic [63:0] grant_q[$];

    instr_cache_repl_ctlr #(.B(64), .BEATS(8)) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .ic_miss_i      (ic_miss_i),
        .pc_i           (pc_i),
        .flush_i        (flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .ic_repl_grant_o(ic_repl_grant_o),
        .rep_word_o     (rep_word_o),
        .stall_o        (stall_o),
        .refill_done_o  (refill_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every grant and completion pulse seen on the cache side
    always @(posedge clk_i) begin
        #2;
        if (ic_repl_grant_o) grant_q.push_back(rep_word_o);
        if (refill_done_o) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input int n);
        return {32'hC0DE0000 + 32'(n), 32'h00001200 + 32'(n * 8)};
    endfunction

    task automatic chk_grants(input int n_exp, input int done_exp);
        chk("n_grants", 64'(grant_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < grant_q.size(); i++)
            chk("beat_order", grant_q[i], beat_data(i));
        chk("n_done", 64'(n_done), 64'(done_exp));
    endtask

    // Full refill of pc 0x1234 with optional ack delay, inter-beat gaps,
    // flush coincident with ack, flush on a given beat, and a miss in DONE.
    task automatic refill(input int ack_wait, input int gap, input bit flush_w_ack,
                          input int flush_beat, input bit miss_in_done);
        int cyc;
        grant_q.delete();
        n_done = 0;
        cyc = 0;
        ic_miss_i = 1'b1;
        pc_i = 32'h0000_1234;
        tick(); cyc++;
        ic_miss_i = 1'b0;
        pc_i = 32'hFFFF_FFFF;
        for (int w = 0; w < ack_wait; w++) begin
            chk("req_held", 64'(mem_req_o), 64'd1);
            chk("addr_stable", 64'(mem_addr_o), 64'h1200);
            tick(); cyc++;
        end
        chk("req_ack_cycle", 64'(mem_req_o), 64'd1);
        chk("addr_ack_cycle", 64'(mem_addr_o), 64'h1200);
        chk("stall_req", 64'(stall_o), 64'd1);
        mem_ack_i = 1'b1;
        flush_i = flush_w_ack;
        tick(); cyc++;
        mem_ack_i = 1'b0;
        flush_i = 1'b0;
        chk("req_drop_fill", 64'(mem_req_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid_i = 1'b0;
                    tick(); cyc++;
                    chk("gap_no_grant", 64'(ic_repl_grant_o), 64'd0);
                    chk("gap_hold_word", rep_word_o, beat_data(i - 1));
                end
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i = beat_data(i);
            flush_i = (i == flush_beat);
            tick(); cyc++;
            mem_rvalid_i = 1'b0;
            mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
            flush_i = 1'b0;
            chk("grant_next", 64'(ic_repl_grant_o), 64'd1);
            chk("word_next", rep_word_o, beat_data(i));
        end
        chk("done_pulse", 64'(refill_done_o), 64'd1);
        chk("stall_done", 64'(stall_o), 64'd1);
        ic_miss_i = miss_in_done;
        mem_rvalid_i = 1'b1;
        tick(); cyc++;
        mem_rvalid_i = 1'b0;
        chk("idle_stall", 64'(stall_o), 64'd0);
        chk("idle_done", 64'(refill_done_o), 64'd0);
        chk("idle_no_req", 64'(mem_req_o), 64'd0);
        chk("idle_no_grant", 64'(ic_repl_grant_o), 64'd0);
        chk("miss_to_idle", 64'(cyc), 64'(3 + ack_wait + 8 + 7 * gap));
        if (miss_in_done) begin
            tick();
            ic_miss_i = 1'b0;
            chk("miss_after_done", 64'(mem_req_o), 64'd1);
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            chk("flush_req_idle", 64'(stall_o), 64'd0);
        end
        tick();
        chk_grants(8, 1);
    endtask

    initial begin
        reset_n_i = 1'b0;
        ic_miss_i = 1'b0;
        pc_i = '0;
        flush_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        tick(); tick();
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_grant", 64'(ic_repl_grant_o), 64'd0);
        chk("rst_word", rep_word_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_done", 64'(refill_done_o), 64'd0);
        reset_n_i = 1'b1;
        tick();

        // zero-wait refill
        refill(0, 0, 1'b0, -1, 1'b0);
        // slow memory: ack after 3 extra cycles, 1-cycle beat gaps
        refill(3, 1, 1'b0, -1, 1'b0);

        // flush in REQ before ack cancels, beats in IDLE are ignored
        grant_q.delete();
        n_done = 0;
        ic_miss_i = 1'b1;
        pc_i = 32'h0000_5678;
        tick();
        ic_miss_i = 1'b0;
        chk("flush_pre_req", 64'(mem_req_o), 64'd1);
        chk("flush_pre_addr", 64'(mem_addr_o), 64'h5640);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_req_drop", 64'(mem_req_o), 64'd0);
        chk("flush_stall_drop", 64'(stall_o), 64'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i = beat_data(0);
        tick(); tick();
        mem_rvalid_i = 1'b0;
        tick();
        chk_grants(0, 0);

        // flush together with ack, then flush mid-fill with miss in DONE
        refill(0, 0, 1'b1, -1, 1'b0);
        refill(0, 0, 1'b0, 3, 1'b1);

        // reset during beat 5
        grant_q.delete();
        n_done = 0;
        ic_miss_i = 1'b1;
        pc_i = 32'h0000_1234;
        tick();
        ic_miss_i = 1'b0;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = beat_data(i);
            tick();
        end
        mem_rdata_i = beat_data(5);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("arst_req", 64'(mem_req_o), 64'd0);
        chk("arst_addr", 64'(mem_addr_o), 64'd0);
        chk("arst_grant", 64'(ic_repl_grant_o), 64'd0);
        chk("arst_word", rep_word_o, 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd0);
        chk("arst_done", 64'(refill_done_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0;
        reset_n_i = 1'b1;
        tick(); tick();
        chk("arst_idle_stall", 64'(stall_o), 64'd0);
        chk_grants(5, 0);
        refill(0, 0, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_cache_repl_ctlr.md
INSTR_CACHE_REPL_CTLR -- requirements
Module: instr_cache_repl_ctlr

Interface
REQ-001 Parameter: B, default 64, cache block size in bytes (power of 2, at least 8).
REQ-002 Parameter: BEATS, default B/8, number of 64-bit memory beats per block refill.
REQ-003 The clock port SHALL be named clk_i; it is the single clock and all state updates occur on its rising edge.
REQ-004 The reset port SHALL be named reset_n_i; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
 clk_i  in  1  clock
 reset_n_i  in  1  async active-low reset
 ic_miss_i  in  1  instruction cache set reports a miss for the current fetch
 pc_i  in  32  fetch address of the missing instruction
 flush_i  in  1  pipeline flush (redirect); cancels a pending refill
 mem_req_o  out  1  refill request to memory
 mem_addr_o  out  32  block-aligned refill address
 mem_ack_i  in  1  memory accepted the request
 mem_rvalid_i  in  1  memory return beat valid
 mem_rdata_i  in  64  memory return beat data
 ic_repl_grant_o  out  1  write rep_word_o into the cache set this cycle
 rep_word_o  out  64  replacement word to the cache set
 stall_o  out  1  refill in progress; fetch must hold
 refill_done_o  out  1  one-cycle pulse after the final beat is written

Function
REQ-006 The FSM SHALL have four states: IDLE, REQ, FILL and DONE.
REQ-007 IDLE: when ic_miss_i=1 and flush_i=0, the FSM SHALL go to REQ and latch mem_addr_o = pc_i with the low log2(B) bits cleared.
REQ-008 REQ: mem_req_o SHALL be 1 and mem_addr_o SHALL be stable until mem_ack_i=1; on ack the FSM SHALL go to FILL and clear beat_cnt to 0.
REQ-009 REQ with flush_i=1 and mem_ack_i=0: the FSM SHALL return to IDLE and deassert mem_req_o on the next cycle.
REQ-010 REQ with flush_i=1 and mem_ack_i=1 in the same cycle: the ack wins, the FSM enters FILL, and the flush is recorded in flush_pend.
REQ-011 FILL: each cycle with mem_rvalid_i=1 SHALL register rep_word_o <= mem_rdata_i and ic_repl_grant_o <= 1, and increment beat_cnt (width log2(BEATS)+1).
REQ-012 FILL: a cycle with mem_rvalid_i=0 SHALL register ic_repl_grant_o <= 0 and SHALL hold rep_word_o.
REQ-013 Beat ordering: beat n carries block bytes [n*8 +: 8], and beats are forwarded in arrival order.
REQ-014 FILL: on the beat that makes beat_cnt = BEATS, the FSM SHALL go to DONE; mem_rvalid_i is ignored outside FILL.
REQ-015 flush_i asserted during FILL SHALL NOT abort the fill; it sets flush_pend, and all BEATS beats are still written.
REQ-016 DONE: refill_done_o SHALL be 1 for exactly one cycle, ic_repl_grant_o carries the final beat, and the FSM SHALL go to IDLE next cycle.
REQ-017 DONE: flush_pend SHALL be cleared; ic_miss_i in this cycle SHALL NOT start a new request.
REQ-018 stall_o SHALL equal (state != IDLE); it is combinational from state.
REQ-019 Latency: ic_miss_i sampled in cycle N gives mem_req_o=1 in N+1. A beat accepted in cycle k gives ic_repl_grant_o=1 in k+1.
REQ-020 Minimum refill time with zero-wait memory (ack in the first REQ cycle, rvalid on every cycle) is BEATS+3 cycles from miss to IDLE.

Reset
REQ-021 reset_n_i=0 SHALL immediately force: state=IDLE, mem_req_o=0, mem_addr_o=0, ic_repl_grant_o=0, rep_word_o=0, refill_done_o=0, stall_o=0, beat_cnt=0, flush_pend=0.
REQ-022 Reset asserted mid-FILL SHALL abandon the refill without emitting a grant; after release the block waits in IDLE for a new miss.

Verification
REQ-023 Zero-wait refill: pc_i=0x0000_1234, miss -> mem_addr_o=0x0000_1200; 8 beats on consecutive cycles -> 8 consecutive grants; refill_done_o pulses once; stall_o low after 11 cycles.
REQ-024 Stalled memory: ack delayed 3 cycles, beats with 1-cycle gaps -> mem_req_o held 4 cycles, address stable; exactly 8 grants; data matches beat order.
REQ-025 Flush in REQ before ack -> IDLE next cycle, no grants. Flush coincident with ack -> full 8-beat fill completes, then a single refill_done_o pulse.
REQ-026 Flush mid-FILL after beat 3 -> remaining 5 beats are still granted; refill_done_o=1; a miss in the DONE cycle is ignored and is accepted one cycle later in IDLE.
REQ-027 reset_n_i low during beat 5 -> all outputs are 0 asynchronously, no further grants; a subsequent miss refills normally.
